// File: rtl/axi_rd_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | axi_rd_arbiter_pkg : shared cache/AXI read-path types and constants         |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
package axi_rd_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2
  } rd_state_e;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  localparam logic [3:0] ARID_I = 4'd0;
  localparam logic [3:0] ARID_D = 4'd1;

  // Cache line bursts always move full 32-bit words.
  localparam logic [2:0] ARSIZE_LINE = 3'b010;

  // Bit positions inside the one-hot grant vector.
  localparam int GNT_I = 0;
  localparam int GNT_D = 1;

endpackage
`default_nettype wire

// File: rtl/axi_rd_arbiter_rd_grant_sel.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rd_grant_sel : one-hot grant between I and D read requesters               |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module rd_grant_sel
  import axi_rd_arbiter_pkg::*;
(
  input  logic       i_req,
  input  logic       d_req,
  input  logic       prio_d,
  output logic [1:0] grant
);

  // A lone request always wins; on contention prio_d picks the side.
  always_comb begin
    grant        = 2'b00;
    grant[GNT_D] = d_req & (~i_req | prio_d);
    grant[GNT_I] = i_req & (~d_req | ~prio_d);
  end

endmodule
`default_nettype wire

// File: rtl/axi_rd_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | axi_rd_arbiter : I/D cache read arbiter onto a single AXI AR/R channel      |
// | Optional macro AXI_RD_RR_EN selects round-robin instead of D-first priority |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module axi_rd_arbiter
  import axi_rd_arbiter_pkg::*;
#(
  parameter logic [7:0] I_AXI_LEN = 8'd7,
  parameter logic [7:0] D_AXI_LEN = 8'd3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_idle,

  input  logic        i_rd_req,
  input  logic [31:0] i_rd_addr,
  input  logic [1:0]  i_rd_size,
  input  logic        i_burst,
  output logic        i_rd_rdy,
  output logic        i_ret_valid,

  input  logic        d_rd_req,
  input  logic [31:0] d_rd_addr,
  input  logic [1:0]  d_rd_size,
  input  logic        d_burst,
  output logic        d_rd_rdy,
  output logic        d_ret_valid,

  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,

  input  logic        rvalid,
  input  logic        rlast,
  output logic        rready
);

  rd_state_e   r_state;
  rd_state_e   w_state_next;
  logic [1:0]  w_grant;
  logic        w_grant_en;
  logic        w_prio_d;

  logic        r_owner_d;
  logic [31:0] r_addr;
  logic [1:0]  r_size;
  logic        r_burst;

`ifdef AXI_RD_RR_EN
  logic r_prio_d;

  // The side just granted loses priority on the next contention.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prio_d <= 1'b1;
    end else if (w_grant_en) begin
      r_prio_d <= w_grant[GNT_I];
    end
  end

  assign w_prio_d = r_prio_d;
`else
  assign w_prio_d = 1'b1;
`endif

  rd_grant_sel u_grant_sel (
    .i_req  (i_rd_req),
    .d_req  (d_rd_req),
    .prio_d (w_prio_d),
    .grant  (w_grant)
  );

  assign w_grant_en = (r_state == ST_IDLE) & wr_idle & (i_rd_req | d_rd_req);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_owner_d <= 1'b0;
      r_addr    <= 32'd0;
      r_size    <= 2'd0;
      r_burst   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_grant_en) begin
        r_owner_d <= w_grant[GNT_D];
        r_addr    <= ({32{w_grant[GNT_D]}} & d_rd_addr) | ({32{w_grant[GNT_I]}} & i_rd_addr);
        r_size    <= ({2{w_grant[GNT_D]}} & d_rd_size) | ({2{w_grant[GNT_I]}} & i_rd_size);
        r_burst   <= (w_grant[GNT_D] & d_burst) | (w_grant[GNT_I] & i_burst);
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    arvalid      = 1'b0;
    rready       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_en) w_state_next = ST_AR;
      end
      ST_AR: begin
        arvalid = 1'b1;
        if (arready) w_state_next = ST_R;
      end
      ST_R: begin
        rready = 1'b1;
        if (rvalid && rlast) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // AR payload comes only from the latched request so it cannot move while waiting.
  assign arid    = r_owner_d ? ARID_D : ARID_I;
  assign araddr  = r_addr;
  assign arlen   = r_burst ? (r_owner_d ? D_AXI_LEN : I_AXI_LEN) : 8'd0;
  assign arsize  = r_burst ? ARSIZE_LINE : {1'b0, r_size};
  assign arburst = r_burst ? BURST_INCR : BURST_FIXED;

  assign i_rd_rdy    = arvalid & arready & ~r_owner_d;
  assign d_rd_rdy    = arvalid & arready &  r_owner_d;
  assign i_ret_valid = rready & rvalid & ~r_owner_d;
  assign d_ret_valid = rready & rvalid &  r_owner_d;

endmodule
`default_nettype wire

// File: tb/tb_axi_rd_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_axi_rd_arbiter : directed + randomized self-checking bench              |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_axi_rd_arbiter;

  logic        clk = 1'b0;
  logic        reset, wr_idle;
  logic        i_rd_req, i_burst, i_rd_rdy, i_ret_valid;
  logic [31:0] i_rd_addr;
  logic [1:0]  i_rd_size;
  logic        d_rd_req, d_burst, d_rd_rdy, d_ret_valid;
  logic [31:0] d_rd_addr;
  logic [1:0]  d_rd_size;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid, arready, rvalid, rlast, rready;

  int checks = 0;
  int errors = 0;
  bit checking = 1'b0;

  always #5 clk = ~clk;

  axi_rd_arbiter dut (
    .clk(clk), .reset(reset), .wr_idle(wr_idle),
    .i_rd_req(i_rd_req), .i_rd_addr(i_rd_addr), .i_rd_size(i_rd_size), .i_burst(i_burst),
    .i_rd_rdy(i_rd_rdy), .i_ret_valid(i_ret_valid),
    .d_rd_req(d_rd_req), .d_rd_addr(d_rd_addr), .d_rd_size(d_rd_size), .d_burst(d_burst),
    .d_rd_rdy(d_rd_rdy), .d_ret_valid(d_ret_valid),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rvalid(rvalid), .rlast(rlast), .rready(rready)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level reference: one pending read (busy), address phase done or not.
  bit          m_busy, m_ar_done, m_owner_d, m_burst, m_prefer_d;
  logic [31:0] m_addr;
  logic [1:0]  m_size;

  function automatic bit pick_d(input bit iq, input bit dq, input bit prefer_d);
`ifdef AXI_RD_RR_EN
    return dq && (!iq || prefer_d);
`else
    return dq || (prefer_d && !iq);
`endif
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_busy <= 0; m_ar_done <= 0; m_owner_d <= 0; m_burst <= 0;
      m_addr <= '0; m_size <= '0; m_prefer_d <= 1;
    end else if (!m_busy) begin
      if (wr_idle && (i_rd_req || d_rd_req)) begin
        m_busy     <= 1;
        m_ar_done  <= 0;
        m_owner_d  <= pick_d(i_rd_req, d_rd_req, m_prefer_d);
        m_prefer_d <= !pick_d(i_rd_req, d_rd_req, m_prefer_d);
        m_addr     <= pick_d(i_rd_req, d_rd_req, m_prefer_d) ? d_rd_addr : i_rd_addr;
        m_size     <= pick_d(i_rd_req, d_rd_req, m_prefer_d) ? d_rd_size : i_rd_size;
        m_burst    <= pick_d(i_rd_req, d_rd_req, m_prefer_d) ? d_burst : i_burst;
      end
    end else if (!m_ar_done) begin
      if (arready) m_ar_done <= 1;
    end else if (rvalid && rlast) begin
      m_busy <= 0;
    end
  end

  logic e_arv, e_rr;
  always @(negedge clk) begin
    if (checking) begin
      e_arv = m_busy && !m_ar_done;
      e_rr  = m_busy && m_ar_done;
      chk("arvalid", arvalid, e_arv);
      chk("rready", rready, e_rr);
      chk("araddr", araddr, m_addr);
      chk("arid", arid, m_owner_d ? 1 : 0);
      chk("arlen", arlen, m_burst ? (m_owner_d ? 3 : 7) : 0);
      chk("arsize", arsize, m_burst ? 2 : m_size);
      chk("arburst", arburst, m_burst ? 1 : 0);
      chk("i_rd_rdy", i_rd_rdy, e_arv && arready && !m_owner_d);
      chk("d_rd_rdy", d_rd_rdy, e_arv && arready && m_owner_d);
      chk("i_ret_valid", i_ret_valid, e_rr && rvalid && !m_owner_d);
      chk("d_ret_valid", d_ret_valid, e_rr && rvalid && m_owner_d);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int beats;
    int got;
    logic [3:0] ids [3];
    reset = 1; wr_idle = 1;
    i_rd_req = 0; i_rd_addr = '0; i_rd_size = '0; i_burst = 0;
    d_rd_req = 0; d_rd_addr = '0; d_rd_size = '0; d_burst = 0;
    arready = 0; rvalid = 0; rlast = 0;
    tick(); tick();
    reset = 0;
    checking = 1'b1;
    @(negedge clk);
    chk("reset_arvalid", arvalid, 0);
    chk("reset_rready", rready, 0);
    chk("reset_araddr", araddr, 0);

    // Single I burst.
    i_rd_req = 1; i_rd_addr = 32'h1000_0020; i_burst = 1; arready = 1;
    tick();
    i_rd_req = 0;
    @(negedge clk);
    chk("i_ar_valid", arvalid, 1);
    chk("i_ar_addr", araddr, 32'h1000_0020);
    chk("i_ar_len", arlen, 7);
    chk("i_ar_size", arsize, 2);
    chk("i_ar_burst", arburst, 1);
    chk("i_ar_id", arid, 0);
    chk("i_ar_rdy", i_rd_rdy, 1);
    tick();
    beats = 0;
    for (int k = 0; k < 8; k++) begin
      rvalid = 1; rlast = (k == 7);
      @(negedge clk);
      if (i_ret_valid) beats++;
      tick();
    end
    rvalid = 0; rlast = 0;
    @(negedge clk);
    chk("i_beats", beats, 8);
    chk("i_idle_rready", rready, 0);

    // Simultaneous requests held.
    i_rd_req = 1; d_rd_req = 1; d_rd_addr = 32'h0000_0100; d_burst = 1;
    arready = 1; rvalid = 1; rlast = 1;
    got = 0;
    for (int c = 0; c < 15 && got < 3; c++) begin
      @(negedge clk);
      if (arvalid) begin ids[got] = arid; got++; end
      tick();
    end
    chk("arb_count", got, 3);
`ifdef AXI_RD_RR_EN
    chk("arb_0", ids[0], 1); chk("arb_1", ids[1], 0); chk("arb_2", ids[2], 1);
`else
    chk("arb_0", ids[0], 1); chk("arb_1", ids[1], 1); chk("arb_2", ids[2], 1);
`endif
    i_rd_req = 0; d_rd_req = 0;
    repeat (4) tick();
    arready = 0; rvalid = 0; rlast = 0;

    // Write engine busy blocks the grant; then AR back-pressure.
    wr_idle = 0; d_rd_req = 1; d_rd_addr = 32'h2000_0040; d_rd_size = 0; d_burst = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("wr_busy_arvalid", arvalid, 0);
      tick();
    end
    wr_idle = 1;
    tick();
    d_rd_req = 0;
    @(negedge clk);
    chk("wr_rise_arvalid", arvalid, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_rdy", d_rd_rdy, 0);
      chk("stall_addr", araddr, 32'h2000_0040);
      chk("stall_len", arlen, 3);
      tick();
    end
    arready = 1;
    @(negedge clk);
    chk("stall_rdy_pulse", d_rd_rdy, 1);
    tick();
    arready = 0;
    @(negedge clk);
    chk("post_rdy", d_rd_rdy, 0);
    chk("post_rready", rready, 1);
    rvalid = 1; rlast = 1;
    tick();
    rvalid = 0; rlast = 0;

    // Uncached D read, then reset while in R.
    d_rd_req = 1; d_rd_addr = 32'h1FAF_0002; d_rd_size = 1; d_burst = 0; arready = 1;
    tick();
    d_rd_req = 0;
    @(negedge clk);
    chk("unc_len", arlen, 0);
    chk("unc_size", arsize, 1);
    chk("unc_burst", arburst, 0);
    chk("unc_id", arid, 1);
    tick();
    @(negedge clk);
    chk("unc_rready", rready, 1);
    reset = 1;
    tick();
    reset = 0;
    @(negedge clk);
    chk("rst_rready", rready, 0);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_addr", araddr, 0);
    for (int k = 0; k < 3; k++) begin
      rvalid = 1; rlast = (k == 2);
      @(negedge clk);
      chk("rst_ret", d_ret_valid, 0);
      tick();
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      reset     = ($urandom_range(199) == 0);
      wr_idle   = ($urandom_range(3) != 0);
      i_rd_req  = $urandom_range(1);
      d_rd_req  = $urandom_range(1);
      i_rd_addr = $urandom; d_rd_addr = $urandom;
      i_rd_size = 2'($urandom_range(3)); d_rd_size = 2'($urandom_range(3));
      i_burst   = $urandom_range(1); d_burst = $urandom_range(1);
      arready   = $urandom_range(1);
      rvalid    = $urandom_range(1);
      rlast     = ($urandom_range(2) == 0);
      tick();
    end
    checking = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
